// File: rtl/spi_reg_bank.sv
// Parametrised SPI register bank sitting behind spi_slave on clk_core.
// Byte 0 of a transaction is the command (bit 7 = write, [6:0] = start address); the data bytes that follow auto-increment the address.
module spi_reg_bank #(
  parameter int                    NUM_REGS     = 8,
  parameter logic [7:0]            FPGA_VER     = 8'hC2,
  parameter logic [NUM_REGS-1:0]   RW_MASK      = NUM_REGS'(8'b0000_0010),
  parameter logic [8*NUM_REGS-1:0] RESET_VALUES = {8*NUM_REGS{1'b0}}
) (
  input  logic                    clk_core,
  input  logic                    reset,
  input  logic                    transaction_begin,
  input  logic                    rx_byte_available,
  input  logic [7:0]              rx_byte,
  output logic [7:0]              tx_byte,
  input  logic [8*NUM_REGS-1:0]   reg_in,
  output logic [8*NUM_REGS-1:0]   reg_out,
  output logic [NUM_REGS-1:0]     reg_wr_strobe,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        rx_sync_q;
  logic              rx_edge;
  logic [6:0]        pointer_q, pointer_d;
  logic              cmd_write_q, cmd_write_d;
  logic [7:0]        tx_q, tx_d;
  logic              wr_fire;
  logic [NUM_REGS-1:0] strobe_q, strobe_d;

  // Full 7-bit address map: read value and writability for every address.
  logic [7:0]        rd_table [128];
  logic [127:0]      wr_ok;

  // Byte handshake: spi_slave holds rx_byte stable while rx_byte_available
  // is high; each rising edge of that level is exactly one new byte and
  // there is no back-pressure, so every byte is consumed in its edge cycle.
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      rx_sync_q <= 2'b00;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_byte_available};
    end
  end

  assign rx_edge = (rx_sync_q == 2'b01);

  for (genvar g = 0; g < 128; g++) begin : g_map
    if (g == 0) begin : g_ver
      assign rd_table[g] = FPGA_VER;
      assign wr_ok[g]    = 1'b0;
      assign reg_out[7:0] = 8'h00;
    end else if (g < NUM_REGS) begin : g_impl
      if (RW_MASK[g]) begin : g_rw
        logic [7:0] value_q;
        always_ff @(posedge clk_core or posedge reset) begin
          if (reset) begin
            value_q <= RESET_VALUES[8*g +: 8];
          end else if (wr_fire && (pointer_q == 7'(g))) begin
            value_q <= rx_byte;
          end
        end
        assign rd_table[g]       = value_q;
        assign wr_ok[g]          = 1'b1;
        assign reg_out[8*g +: 8] = value_q;
      end else begin : g_ro
        assign rd_table[g]       = reg_in[8*g +: 8];
        assign wr_ok[g]          = 1'b0;
        assign reg_out[8*g +: 8] = 8'h00;
      end
    end else begin : g_none
      assign rd_table[g] = 8'h00;
      assign wr_ok[g]    = 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_strobe
    assign strobe_d[g] = wr_fire && (pointer_q == 7'(g));
  end

  // transaction_begin outranks a coincident rx_edge, which is simply lost.
  assign wr_fire = !transaction_begin && rx_edge && (state_q == DATA) &&
                   cmd_write_q && wr_ok[pointer_q];

  always_comb begin
    state_d     = state_q;
    pointer_d   = pointer_q;
    cmd_write_d = cmd_write_q;
    tx_d        = tx_q;
    if (transaction_begin) begin
      state_d = ADDR;
      tx_d    = 8'h00;
    end else if (rx_edge) begin
      case (state_q)
        ADDR: begin
          cmd_write_d = rx_byte[7];
          if (rx_byte[7]) begin
            pointer_d = rx_byte[6:0];
          end else begin
            tx_d      = rd_table[rx_byte[6:0]];
            pointer_d = rx_byte[6:0] + 7'd1;
          end
          state_d = DATA;
        end
        DATA: begin
          pointer_d = pointer_q + 7'd1;
          if (cmd_write_q) begin
            tx_d = 8'h00;
          end else begin
            tx_d = rd_table[pointer_q];
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pointer_q   <= 7'd0;
      cmd_write_q <= 1'b0;
      tx_q        <= 8'h00;
      strobe_q    <= '0;
    end else begin
      state_q     <= state_d;
      pointer_q   <= pointer_d;
      cmd_write_q <= cmd_write_d;
      tx_q        <= tx_d;
      strobe_q    <= strobe_d;
    end
  end

  assign tx_byte       = tx_q;
  assign reg_wr_strobe = strobe_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: three instances (default map, mostly-RW map with
// non-zero reset values, 128-register map) checked against a reference model.
module tb_spi_reg_bank;

  localparam logic [63:0] RV_B = 64'h8070_6050_4030_2010;

  logic          clk;
  logic          reset;
  logic [2:0]    tb_begin;
  logic [2:0]    tb_avail;
  logic [7:0]    rx_byte;
  logic [63:0]   reg_in_a, reg_in_b;
  logic [1023:0] reg_in_c;
  logic [7:0]    tx_a, tx_b, tx_c;
  logic [63:0]   out_a, out_b;
  logic [1023:0] out_c;
  logic [7:0]    stb_a, stb_b;
  logic [127:0]  stb_c;
  logic          busy_a, busy_b, busy_c;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0]   exp_q[$];
  logic [127:0] stb_q[$];

  // Reference model state per instance.
  logic [7:0] model [3][128];
  int         mstate [3];
  logic       mwrite [3];
  logic [6:0] mptr [3];
  logic [7:0] mtx [3];

  spi_reg_bank dut_a (
    .clk_core(clk), .reset(reset), .transaction_begin(tb_begin[0]),
    .rx_byte_available(tb_avail[0]), .rx_byte(rx_byte), .tx_byte(tx_a),
    .reg_in(reg_in_a), .reg_out(out_a), .reg_wr_strobe(stb_a), .busy(busy_a)
  );

  spi_reg_bank #(.NUM_REGS(8), .RW_MASK(8'hFE), .RESET_VALUES(RV_B)) dut_b (
    .clk_core(clk), .reset(reset), .transaction_begin(tb_begin[1]),
    .rx_byte_available(tb_avail[1]), .rx_byte(rx_byte), .tx_byte(tx_b),
    .reg_in(reg_in_b), .reg_out(out_b), .reg_wr_strobe(stb_b), .busy(busy_b)
  );

  spi_reg_bank #(.NUM_REGS(128)) dut_c (
    .clk_core(clk), .reset(reset), .transaction_begin(tb_begin[2]),
    .rx_byte_available(tb_avail[2]), .rx_byte(rx_byte), .tx_byte(tx_c),
    .reg_in(reg_in_c), .reg_out(out_c), .reg_wr_strobe(stb_c), .busy(busy_c)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nregs(input int sel);
    return (sel == 2) ? 128 : 8;
  endfunction

  function automatic logic is_rw(input int sel, input logic [6:0] a);
    if (sel == 1) return (a >= 7'd1) && (a <= 7'd7);
    return (a == 7'd1);
  endfunction

  function automatic logic [7:0] model_rd(input int sel, input logic [6:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return 8'hC2;
    if (ai >= nregs(sel)) return 8'h00;
    if (is_rw(sel, a)) return model[sel][ai];
    case (sel)
      0:       return reg_in_a[8*ai +: 8];
      1:       return reg_in_b[8*ai +: 8];
      default: return reg_in_c[8*ai +: 8];
    endcase
  endfunction

  function automatic logic [127:0] model_out(input int sel);
    logic [127:0] r;
    r = '0;
    for (int i = 1; i < 16; i++) begin
      if (i < nregs(sel) && is_rw(sel, 7'(i))) r[8*i +: 8] = model[sel][i];
    end
    return r;
  endfunction

  function automatic logic [127:0] tx_of(input int sel);
    case (sel)
      0:       return {120'd0, tx_a};
      1:       return {120'd0, tx_b};
      default: return {120'd0, tx_c};
    endcase
  endfunction

  function automatic logic [127:0] out_of(input int sel);
    case (sel)
      0:       return {64'd0, out_a};
      1:       return {64'd0, out_b};
      default: return out_c[127:0];
    endcase
  endfunction

  function automatic logic [127:0] stb_of(input int sel);
    case (sel)
      0:       return {120'd0, stb_a};
      1:       return {120'd0, stb_b};
      default: return stb_c;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 128; i++) model[s][i] = 8'h00;
      mstate[s] = 0;
      mwrite[s] = 1'b0;
      mptr[s]   = 7'd0;
      mtx[s]    = 8'h00;
    end
    for (int i = 1; i < 8; i++) model[1][i] = RV_B[8*i +: 8];
  endtask

  // Driver tasks
  task automatic begin_txn(input int sel);
    @(negedge clk);
    tb_begin[sel] = 1'b1;
    @(negedge clk);
    tb_begin[sel] = 1'b0;
    mstate[sel] = 1;
    mtx[sel]    = 8'h00;
    check("begin_tx", tx_of(sel), 128'd0);
    check("begin_busy", {127'd0, busy_of(sel)}, 128'd1);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    logic [7:0]   old_tx;
    logic [127:0] exp_stb;
    logic [6:0]   p;
    old_tx  = mtx[sel];
    exp_stb = '0;
    p       = mptr[sel];
    if (mstate[sel] == 1) begin
      mwrite[sel] = b[7];
      if (b[7]) begin
        mptr[sel] = b[6:0];
      end else begin
        mtx[sel]  = model_rd(sel, b[6:0]);
        mptr[sel] = b[6:0] + 7'd1;
      end
      mstate[sel] = 2;
    end else if (mstate[sel] == 2) begin
      if (mwrite[sel]) begin
        if (int'(p) < nregs(sel) && is_rw(sel, p)) begin
          model[sel][int'(p)] = b;
          exp_stb[p] = 1'b1;
        end
        mtx[sel] = 8'h00;
      end else begin
        mtx[sel] = model_rd(sel, p);
      end
      mptr[sel] = p + 7'd1;
    end
    exp_q.push_back(mtx[sel]);
    stb_q.push_back(exp_stb);

    @(negedge clk);
    rx_byte       = b;
    tb_avail[sel] = 1'b1;
    @(negedge clk);
    check("tx_hold", tx_of(sel), {120'd0, old_tx});
    @(negedge clk);
    check("tx", tx_of(sel), {120'd0, exp_q.pop_front()});
    check("strobe", stb_of(sel), stb_q.pop_front());
    check("reg_out", out_of(sel), model_out(sel));
    @(negedge clk);
    check("strobe_clr", stb_of(sel), 128'd0);
    tb_avail[sel] = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_with_edge(input int sel, input logic [7:0] b);
    @(negedge clk);
    rx_byte       = b;
    tb_avail[sel] = 1'b1;
    @(negedge clk);
    tb_begin[sel] = 1'b1;
    @(negedge clk);
    tb_begin[sel] = 1'b0;
    mstate[sel] = 1;
    mtx[sel]    = 8'h00;
    check("prio_tx", tx_of(sel), 128'd0);
    check("prio_busy", {127'd0, busy_of(sel)}, 128'd1);
    check("prio_strobe", stb_of(sel), 128'd0);
    @(negedge clk);
    tb_avail[sel] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_tx", tx_of(s), 128'd0);
      check("rst_busy", {127'd0, busy_of(s)}, 128'd0);
      check("rst_strobe", stb_of(s), 128'd0);
      check("rst_reg_out", out_of(s), model_out(s));
    end
    check("rst_values_b", {64'd0, out_b}, {64'd0, 64'h8070_6050_4030_2000});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [6:0] addr;
    int         wr;
    int         n;
    reset    = 1'b1;
    tb_begin = 3'b000;
    tb_avail = 3'b000;
    rx_byte  = 8'h00;
    reg_in_a = {$urandom, $urandom};
    reg_in_b = {$urandom, $urandom};
    reg_in_c = '0;
    reg_in_c[1023:1016] = 8'h3C;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // IDLE ignores bytes
    send_byte(0, 8'h00);

    // Version read
    begin_txn(0);
    send_byte(0, 8'h00);
    send_byte(0, 8'hFF);

    // Single write, then read back
    begin_txn(0);
    send_byte(0, 8'h81);
    send_byte(0, 8'h01);
    begin_txn(0);
    send_byte(0, 8'h01);

    // RO protection and out-of-range
    begin_txn(0);
    send_byte(0, 8'h80);
    send_byte(0, 8'h55);
    begin_txn(0);
    send_byte(0, 8'h8A);
    send_byte(0, 8'h77);
    begin_txn(0);
    send_byte(0, 8'h0A);

    // Live RO value sampled at load time
    reg_in_a[39:32] = 8'h5A;
    begin_txn(0);
    send_byte(0, 8'h04);
    reg_in_a[39:32] = 8'h00;
    @(negedge clk);
    check("ro_sampled", {120'd0, tx_a}, 128'h5A);
    send_byte(0, 8'h00);

    // Burst write and burst read on the mostly-RW map
    begin_txn(1);
    send_byte(1, 8'h81);
    send_byte(1, 8'h11);
    send_byte(1, 8'h22);
    send_byte(1, 8'h33);
    begin_txn(1);
    send_byte(1, 8'h01);
    send_byte(1, 8'h00);
    send_byte(1, 8'h00);
    send_byte(1, 8'h00);

    // Begin coincident with a byte edge
    begin_txn(0);
    send_byte(0, 8'h00);
    begin_with_edge(0, 8'h01);
    send_byte(0, 8'h00);

    // Pointer wrap on the 128-register map
    begin_txn(2);
    send_byte(2, 8'h7F);
    send_byte(2, 8'h00);
    begin_txn(2);
    send_byte(2, 8'hFF);
    send_byte(2, 8'h99);
    send_byte(2, 8'hAB);
    send_byte(2, 8'h5C);

    // Random transactions
    for (int t = 0; t < 10; t++) begin
      begin_txn(1);
      addr = 7'($urandom_range(0, 9));
      wr   = $urandom_range(0, 1);
      n    = $urandom_range(1, 4);
      send_byte(1, {wr[0], addr});
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom_range(0, 255));
        send_byte(1, d);
      end
    end

    // Reset in the middle of a burst
    begin_txn(1);
    send_byte(1, 8'h81);
    send_byte(1, 8'hA5);
    send_byte(1, 8'h5A);
    do_reset();
    send_byte(1, 8'h01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
